// File: rtl/led_qsys_sysid_checker.sv
// Integrity checker for the Qsys sysid slave: reads the ID and timestamp words over
// Avalon-MM, compares them against build-time values and reports status on the LEDs.
module led_qsys_sysid_checker #(
    parameter logic [31:0] EXP_ID         = 32'd0,
    parameter logic [31:0] EXP_TS         = 32'd1729754342,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned RECHECK_CYCLES = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        mismatch_id,
    output logic        mismatch_ts,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  led
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ID   = 3'd1;
    localparam logic [2:0] ST_WAIT_ID = 3'd2;
    localparam logic [2:0] ST_RD_TS   = 3'd3;
    localparam logic [2:0] ST_WAIT_TS = 3'd4;
    localparam logic [2:0] ST_CMP     = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [23:0] RCK_LAST = 24'(RECHECK_CYCLES - 32'd1);
    localparam logic        RCK_EN   = (RECHECK_CYCLES != 32'd0);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        auto_pend_r;
    logic [15:0] tmo_cnt_r;
    logic [23:0] rck_cnt_r;
    logic        avm_read_r;
    logic        avm_address_r;
    logic        busy_r;
    logic        done_r;
    logic        pass_r;
    logic        mismatch_id_r;
    logic        mismatch_ts_r;
    logic        timeout_r;
    logic [31:0] id_value_r;
    logic [31:0] ts_value_r;

    logic launch_s;
    logic cap_id_s;
    logic cap_ts_s;
    logic abort_s;
    logic cmp_s;
    logic tmo_hit_s;
    logic rck_hit_s;
    logic in_xfer_s;
    logic rd_entry_s;

    assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
    assign rck_hit_s  = RCK_EN && (rck_cnt_r == RCK_LAST);
    assign in_xfer_s  = (state_r == ST_RD_ID) || (state_r == ST_WAIT_ID) ||
                        (state_r == ST_RD_TS) || (state_r == ST_WAIT_TS);
    assign rd_entry_s = ((state_nxt_s == ST_RD_ID) || (state_nxt_s == ST_RD_TS)) &&
                        (state_nxt_s != state_r);

    // Next-state decode; a capture in the deadline cycle still wins over the abort.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        cap_id_s    = 1'b0;
        cap_ts_s    = 1'b0;
        abort_s     = 1'b0;
        cmp_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start || auto_pend_r) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ST_RD_ID;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ID: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    cap_id_s    = 1'b1;
                    state_nxt_s = ST_RD_TS;
                end else if (tmo_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (!avm_waitrequest) begin
                    state_nxt_s = ST_WAIT_ID;
                end else begin
                    state_nxt_s = ST_RD_ID;
                end
            end
            ST_WAIT_ID: begin
                if (avm_readdatavalid) begin
                    cap_id_s    = 1'b1;
                    state_nxt_s = ST_RD_TS;
                end else if (tmo_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_ID;
                end
            end
            ST_RD_TS: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    cap_ts_s    = 1'b1;
                    state_nxt_s = ST_CMP;
                end else if (tmo_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (!avm_waitrequest) begin
                    state_nxt_s = ST_WAIT_TS;
                end else begin
                    state_nxt_s = ST_RD_TS;
                end
            end
            ST_WAIT_TS: begin
                if (avm_readdatavalid) begin
                    cap_ts_s    = 1'b1;
                    state_nxt_s = ST_CMP;
                end else if (tmo_hit_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_TS;
                end
            end
            ST_CMP: begin
                cmp_s       = 1'b1;
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (start || rck_hit_s) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ST_RD_ID;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and bus/status outputs, registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            auto_pend_r   <= AUTO_START;
            avm_read_r    <= 1'b0;
            avm_address_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            auto_pend_r   <= 1'b0;
            avm_read_r    <= (state_nxt_s == ST_RD_ID) || (state_nxt_s == ST_RD_TS);
            avm_address_r <= (state_nxt_s == ST_RD_TS);
            busy_r        <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            done_r        <= (state_nxt_s == ST_DONE);
        end
    end

    // Per-read timeout counter and DONE dwell counter for periodic recheck.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= 16'd0;
            rck_cnt_r <= 24'd0;
        end else begin
            if (rd_entry_s) begin
                tmo_cnt_r <= 16'd0;
            end else if (in_xfer_s) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end
            if (state_r != ST_DONE) begin
                rck_cnt_r <= 24'd0;
            end else begin
                rck_cnt_r <= rck_cnt_r + 24'd1;
            end
        end
    end

    // Captured read data; survives a restart until overwritten.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value_r <= 32'd0;
            ts_value_r <= 32'd0;
        end else begin
            if (cap_id_s) begin
                id_value_r <= avm_readdata;
            end
            if (cap_ts_s) begin
                ts_value_r <= avm_readdata;
            end
        end
    end

    // Result flags: cleared on launch, set by abort or by the compare cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass_r        <= 1'b0;
            mismatch_id_r <= 1'b0;
            mismatch_ts_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else if (launch_s) begin
            pass_r        <= 1'b0;
            mismatch_id_r <= 1'b0;
            mismatch_ts_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else if (abort_s) begin
            pass_r    <= 1'b0;
            timeout_r <= 1'b1;
        end else if (cmp_s) begin
            mismatch_id_r <= (id_value_r != EXP_ID);
            mismatch_ts_r <= (ts_value_r != EXP_TS);
            pass_r        <= (id_value_r == EXP_ID) && (ts_value_r == EXP_TS);
        end
    end

    assign avm_read    = avm_read_r;
    assign avm_address = avm_address_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign mismatch_id = mismatch_id_r;
    assign mismatch_ts = mismatch_ts_r;
    assign timeout     = timeout_r;
    assign id_value    = id_value_r;
    assign ts_value    = ts_value_r;
    assign led         = {timeout_r, mismatch_ts_r, mismatch_id_r, pass_r};

endmodule

// File: tb/tb_led_qsys_sysid_checker.sv
// Directed bench for led_qsys_sysid_checker: one instance with a short timeout and a
// configurable slave, one instance with periodic recheck on an ideal slave.
module tb_led_qsys_sysid_checker;

    localparam logic [31:0] EXP_TS = 32'd1729754342;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        start2  = 1'b0;
    logic [1:0]  mode    = 2'd1;
    logic        wr_v    = 1'b0;
    logic        rdv_v   = 1'b0;
    logic [31:0] rdata_v = 32'd0;
    logic [31:0] id_word = 32'd0;
    logic [31:0] ts_word = 32'd1729754342;

    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, mismatch_id, mismatch_ts, timeout;
    logic [31:0] id_value, ts_value;
    logic [3:0]  led;

    logic        avm_address2, avm_read2;
    logic [31:0] avm_readdata2;
    logic        busy2, done2, pass2, mismatch_id2, mismatch_ts2, timeout2;
    logic [31:0] id_value2, ts_value2;
    logic [3:0]  led2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // mode 0: manual, mode 1: zero-wait/zero-latency, mode 2: stalls forever on address 1
    assign avm_waitrequest   = (mode == 2'd1) ? 1'b0 : ((mode == 2'd2) ? avm_address : wr_v);
    assign avm_readdatavalid = (mode == 2'd1) ? 1'b1 : ((mode == 2'd2) ? ~avm_address : rdv_v);
    assign avm_readdata      = (mode == 2'd0) ? rdata_v :
                               ((mode == 2'd1 && avm_address) ? ts_word : id_word);
    assign avm_readdata2     = avm_address2 ? EXP_TS : 32'd0;

    led_qsys_sysid_checker #(
        .EXP_ID(32'd0), .EXP_TS(EXP_TS), .TIMEOUT_CYCLES(8),
        .AUTO_START(1'b1), .RECHECK_CYCLES(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata),
        .busy(busy), .done(done), .pass(pass), .mismatch_id(mismatch_id),
        .mismatch_ts(mismatch_ts), .timeout(timeout),
        .id_value(id_value), .ts_value(ts_value), .led(led)
    );

    led_qsys_sysid_checker #(
        .EXP_ID(32'd0), .EXP_TS(EXP_TS), .TIMEOUT_CYCLES(1024),
        .AUTO_START(1'b1), .RECHECK_CYCLES(20)
    ) dut_rck (
        .clock(clock), .reset_n(reset_n), .start(start2),
        .avm_address(avm_address2), .avm_read(avm_read2),
        .avm_waitrequest(1'b0), .avm_readdatavalid(1'b1),
        .avm_readdata(avm_readdata2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_id(mismatch_id2),
        .mismatch_ts(mismatch_ts2), .timeout(timeout2),
        .id_value(id_value2), .ts_value(ts_value2), .led(led2)
    );

    task automatic test_reset();
        logic [83:0] obs;
        int k;
        reset_n = 1'b0;
        mode    = 2'd1;
        repeat (3) @(negedge clock);
        obs = {avm_read, avm_address, busy, done, pass, mismatch_id, mismatch_ts, timeout,
               led, id_value, ts_value};
        n_checks++;
        if (obs !== 84'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        obs = {avm_read2, avm_address2, busy2, done2, pass2, mismatch_id2, mismatch_ts2,
               timeout2, led2, id_value2, ts_value2};
        n_checks++;
        if (obs !== 84'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_rck: got %h expected 0", obs);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({avm_read, avm_address, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL auto_start_launch: got %b expected 101", {avm_read, avm_address, busy});
        end
        k = 0;
        while (!done && k < 20) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if ({done, pass, led} !== 6'b110001) begin
            n_fail++;
            $display("FAIL auto_start_result: got %b expected 110001", {done, pass, led});
        end
    endtask

    task automatic test_zero_wait();
        mode    = 2'd1;
        id_word = 32'd0;
        ts_word = EXP_TS;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        n_checks++;
        if ({avm_read, avm_address, busy, done} !== 4'b1010) begin
            n_fail++;
            $display("FAIL zw_rd_id: got %b expected 1010", {avm_read, avm_address, busy, done});
        end
        @(negedge clock);
        n_checks++;
        if ({avm_read, avm_address, busy, done} !== 4'b1110) begin
            n_fail++;
            $display("FAIL zw_rd_ts: got %b expected 1110", {avm_read, avm_address, busy, done});
        end
        @(negedge clock);
        n_checks++;
        if ({avm_read, busy, done} !== 3'b010) begin
            n_fail++;
            $display("FAIL zw_cmp: got %b expected 010", {avm_read, busy, done});
        end
        @(negedge clock);
        n_checks++;
        if ({avm_read, busy, done, pass, led} !== 8'b00110001) begin
            n_fail++;
            $display("FAIL zw_done: got %b expected 00110001", {avm_read, busy, done, pass, led});
        end
        n_checks++;
        if ({id_value, ts_value} !== {32'd0, EXP_TS}) begin
            n_fail++;
            $display("FAIL zw_values: got %h/%h expected 0/%h", id_value, ts_value, EXP_TS);
        end
    endtask

    task automatic test_mismatch_ts();
        mode    = 2'd1;
        ts_word = 32'd1729754343;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({done, pass, mismatch_id, mismatch_ts, led} !== 8'b10010100) begin
            n_fail++;
            $display("FAIL mismatch_ts_flags: got %b expected 10010100",
                     {done, pass, mismatch_id, mismatch_ts, led});
        end
        n_checks++;
        if (ts_value !== 32'd1729754343) begin
            n_fail++;
            $display("FAIL mismatch_ts_value: got %0d expected 1729754343", ts_value);
        end
        ts_word = EXP_TS;
    endtask

    task automatic test_mismatch_id();
        mode    = 2'd1;
        id_word = 32'h0000_0005;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({done, pass, led, id_value} !== {1'b1, 1'b0, 4'b0010, 32'h0000_0005}) begin
            n_fail++;
            $display("FAIL mismatch_id: got done=%b pass=%b led=%b id=%h expected 1 0 0010 5",
                     done, pass, led, id_value);
        end
        id_word = 32'd0;
    endtask

    task automatic test_stall();
        logic [31:0] word;
        mode  = 2'd0;
        wr_v  = 1'b1;
        rdv_v = 1'b0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int a = 0; a < 2; a++) begin
            word = (a == 0) ? 32'd0 : EXP_TS;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if ({avm_read, avm_address, busy} !== {1'b1, a[0], 1'b1}) begin
                    n_fail++;
                    $display("FAIL stall_hold a=%0d i=%0d: got %b expected %b",
                             a, i, {avm_read, avm_address, busy}, {1'b1, a[0], 1'b1});
                end
                @(negedge clock);
            end
            wr_v = 1'b0;
            @(negedge clock);
            wr_v = 1'b1;
            n_checks++;
            if ({avm_read, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL stall_read_drop a=%0d: got %b expected 01", a, {avm_read, busy});
            end
            @(negedge clock);
            rdv_v   = 1'b1;
            rdata_v = word;
            @(negedge clock);
            rdv_v   = 1'b0;
            rdata_v = 32'hDEAD_BEEF;
        end
        @(negedge clock);
        n_checks++;
        if ({done, pass, timeout, led, ts_value} !== {3'b110, 4'b0001, EXP_TS}) begin
            n_fail++;
            $display("FAIL stall_result: got done=%b pass=%b tmo=%b led=%b ts=%0d",
                     done, pass, timeout, led, ts_value);
        end
    endtask

    task automatic test_timeout();
        int n;
        mode = 2'd2;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        @(negedge clock);
        n = 0;
        while (avm_read && avm_address && n < 30) begin
            n++;
            @(negedge clock);
        end
        n_checks++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL timeout_read_cycles: got %0d expected 8", n);
        end
        n_checks++;
        if ({avm_read, busy, done, pass, timeout, led} !== 9'b001011000) begin
            n_fail++;
            $display("FAIL timeout_flags: got %b expected 001011000",
                     {avm_read, busy, done, pass, timeout, led});
        end
        mode = 2'd1;
    endtask

    task automatic test_recheck();
        int k;
        int n;
        k = 0;
        while (done2 && k < 100) begin
            @(negedge clock);
            k++;
        end
        while (!done2 && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (done2 !== 1'b1) begin
            n_fail++;
            $display("FAIL recheck_wait_done: got %b expected 1", done2);
        end
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (done2 && n < 100) begin
                n++;
                @(negedge clock);
            end
            n_checks++;
            if (n !== 20) begin
                n_fail++;
                $display("FAIL recheck_hold r=%0d: got %0d cycles expected 20", r, n);
            end
            n_checks++;
            if ({busy2, avm_read2, avm_address2} !== 3'b110) begin
                n_fail++;
                $display("FAIL recheck_relaunch r=%0d: got %b expected 110",
                         r, {busy2, avm_read2, avm_address2});
            end
            start2 = 1'b1;
            n = 0;
            while (!done2 && n < 100) begin
                n++;
                @(negedge clock);
                start2 = 1'b0;
            end
            n_checks++;
            if ({n, pass2, led2} !== {32'd3, 1'b1, 4'b0001}) begin
                n_fail++;
                $display("FAIL recheck_run r=%0d: got busy=%0d pass=%b led=%b expected 3 1 0001",
                         r, n, pass2, led2);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [83:0] obs;
        int k;
        mode  = 2'd0;
        wr_v  = 1'b0;
        rdv_v = 1'b0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({busy, avm_read} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_wait_id: got %b expected 10", {busy, avm_read});
        end
        #2 reset_n = 1'b0;
        #1;
        obs = {avm_read, avm_address, busy, done, pass, mismatch_id, mismatch_ts, timeout,
               led, id_value, ts_value};
        n_checks++;
        if (obs !== 84'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got %h expected 0", obs);
        end
        mode    = 2'd1;
        id_word = 32'd0;
        ts_word = EXP_TS;
        @(negedge clock) reset_n = 1'b1;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if ({done, pass, timeout, led} !== 7'b1100001) begin
            n_fail++;
            $display("FAIL mid_reset_recover: got %b expected 1100001",
                     {done, pass, timeout, led});
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_mismatch_ts();
        test_mismatch_id();
        test_stall();
        test_timeout();
        test_recheck();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_qsys_sysid_checker.md
Name: led_qsys_sysid_checker

Overview:
Boot-time and periodic integrity checker for the system-ID Avalon slave. The block is an Avalon-MM read master that fetches the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values. It exposes pass/fail/timeout status to the LED pins and to soft logic. It sits between the Qsys sysid slave and the LED output block.

Parameters:
EXP_ID, 32'd0, expected word at address 0
EXP_TS, 32'd1729754342, expected word at address 1
TIMEOUT_CYCLES, 1024, max cycles per read (request+response) before abort; range 1..65535
AUTO_START, 1, 1 = launch one check automatically after reset release
RECHECK_CYCLES, 0, 0 = no periodic recheck; else idle cycles in DONE before automatic re-check; range 0..2^24-1

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle check request; ignored while busy=1
avm_address  out  1  word address to sysid slave
avm_read  out  1  read strobe
avm_waitrequest  in  1  slave stall
avm_readdatavalid  in  1  read data valid; may coincide with the accept cycle
avm_readdata  in  32  read data
busy  out  1  check in progress
done  out  1  result valid (level)
pass  out  1  ID and timestamp both matched
mismatch_id  out  1  ID word differed
mismatch_ts  out  1  timestamp word differed
timeout  out  1  a read exceeded TIMEOUT_CYCLES
id_value  out  32  last captured ID word
ts_value  out  32  last captured timestamp word
led  out  4  {timeout, mismatch_ts, mismatch_id, pass}

Behaviour:
- One clock; reset is asynchronous and active-low (clock, reset_n). All outputs are registered. Every output resets to 0. The state resets to IDLE.
- States:
  - IDLE: busy=0.
  - RD_ID, RD_TS: avm_read=1. avm_address is 0 in RD_ID and 1 in RD_TS.
  - WAIT_ID, WAIT_TS: avm_read=0, waiting for readdatavalid.
  - CMP: evaluate the result.
  - DONE: hold the result.
- IDLE -> RD_ID when start=1, or on the first cycle after reset release if AUTO_START=1. On entry, done, pass, mismatch_*, and timeout clear to 0. id_value and ts_value hold until overwritten.
- Handshake:
  - avm_read and avm_address are held stable until a cycle with avm_waitrequest=0 (the accept cycle).
  - avm_read drops the cycle after accept.
  - Exactly one read is outstanding at a time.
- Response capture:
  - readdatavalid in the accept cycle: capture avm_readdata and go to the next read state directly (RD_ID -> RD_TS, RD_TS -> CMP).
  - Otherwise go to WAIT_x and capture on the first readdatavalid.
  - readdatavalid seen in IDLE, DONE, or any state with nothing outstanding is ignored.
- Timeout:
  - A 16-bit counter reloads to 0 on entry to RD_ID and RD_TS, and increments each cycle in RD_x/WAIT_x.
  - When the count reaches TIMEOUT_CYCLES-1 without capture: avm_read drops, timeout=1, pass=0, and the FSM goes directly to DONE, skipping CMP.
- CMP (one cycle): mismatch_id = (id_value != EXP_ID); mismatch_ts = (ts_value != EXP_TS); pass = !(mismatch_id | mismatch_ts). Go to DONE.
- DONE:
  - done=1 and busy=0; flags hold.
  - start=1 restarts at RD_ID with the same clearing as in IDLE.
  - If RECHECK_CYCLES != 0, a 24-bit counter counts DONE cycles. At RECHECK_CYCLES-1 it auto-restarts. The counter resets on DONE entry.
- busy=1 in RD_x, WAIT_x, and CMP.
- led mirrors the flags combinationally from registers, with no extra latency.
- Latency with a zero-wait, zero-latency slave: start sampled at edge N gives RD_ID at N+1, RD_TS at N+2, CMP at N+3, and done=1 from N+4.
- Reset mid-read: the outstanding read is abandoned and avm_read=0 immediately. AUTO_START re-launches after reset release.
- start and auto-recheck in the same cycle: treated as a single restart.

Test Plan:
- Zero-wait, zero-latency slave returning 0 / 1729754342, start pulse -> reads of addr 0 then 1 on consecutive cycles; done=1 at N+4, pass=1, led=4'b0001.
- Slave returns timestamp 1729754343 -> mismatch_ts=1, pass=0, led=4'b0100, ts_value=1729754343.
- waitrequest held 3 cycles per read, readdatavalid 2 cycles after accept -> address stable during stall; one read outstanding; pass=1; no timeout.
- TIMEOUT_CYCLES=8, waitrequest stuck high on addr 1 -> avm_read drops after 8 cycles in RD_TS; timeout=1, led=4'b1000, done=1.
- RECHECK_CYCLES=20, AUTO_START=1 -> check launches after reset; re-check starts 20 cycles after each DONE entry; start pulses while busy are ignored.
- reset_n asserted mid-WAIT_ID -> all outputs 0 asynchronously; after release a new check completes with pass=1.
